int_controller: RTL

//  Multi-source Z80 maskable-interrupt controller; parametrised successor of the fixed frame-INT generator.

---
 rtl/int_controller_if.sv | 9 +
 rtl/int_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller_if.sv
// cpu_bus: Z80 control strobes observed by the interrupt controller.
// m1 and iorq are active high here; their coincidence marks an INTACK cycle.
interface cpu_bus;
  logic m1;    // opcode fetch / interrupt acknowledge marker
  logic iorq;  // I/O request

  modport master (output m1, output iorq);
  modport slave  (input m1, input iorq);
endinterface

// File: rtl/int_controller.sv
// int_controller: multi-source Z80 maskable-interrupt controller.
// Source 0 is the frame INT (fires at vc/hc == frame_v/frame_h); sources
// 1..NSRC-1 are rising-edge external requests. n_int is driven either as a
// fixed-length pulse counted in CPU clocks or as a level held until every
// enabled request is acknowledged, and it only changes on clkcpu_ck.
// Optional feature macro: INTCTL_VECTOR_EN -- when defined, an IM2 vector
// (VEC_BASE | sel<<1) is latched at INTACK; otherwise the vector bus reads 8'hFF.
module int_controller #(
  parameter int         NSRC      = 4,
  parameter int         PULSE_LEN = 32,
  parameter logic [7:0] VEC_BASE  = 8'hE0,
  localparam int        EXT_W     = (NSRC > 1) ? NSRC - 1 : 1
) (
  input  logic             clk28,
  input  logic             rst_n,
  cpu_bus.slave            bus,
  input  logic             clkcpu_ck,
  input  logic [8:0]       vc,
  input  logic [8:0]       hc,
  input  logic [8:0]       frame_v,
  input  logic [8:0]       frame_h,
  input  logic [EXT_W-1:0] ext_req,
  input  logic [NSRC-1:0]  src_en,
  input  logic             level_mode,
  output logic             n_int,
  output logic             n_int_next,
  output logic             int_vector_rd,
  output logic [7:0]       int_vector_data,
  output logic [NSRC-1:0]  pending
);

  // Counter must hold PULSE_LEN itself, hence the +1.
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0]  pending_reg, pending_next;
  logic [NSRC-1:0]  sampled_reg, sampled_next;   // pending snapshot taken at pulse start
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             n_int_reg;
  logic [EXT_W-1:0] ext_prev_reg;
  logic             ack_prev_reg;

  // ---------------------------------------------------------------------------
  // Trigger detection
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] trig;

  assign trig[0] = (vc == frame_v) && (hc == frame_h);

  generate
    if (NSRC > 1) begin : g_ext
      for (genvar gi = 1; gi < NSRC; gi++) begin : g_trig
        // External request fires on a 0->1 transition seen across two clk28 cycles.
        assign trig[gi] = ext_req[gi-1] & ~ext_prev_reg[gi-1];
      end
    end else begin : g_no_ext
      // Only the frame source exists; the one-bit ext_req stub is ignored.
      logic unused_ext;
      assign unused_ext = ^{ext_req, ext_prev_reg};
    end
  endgenerate

  // Previous-cycle copy of the external requests for edge detection.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) ext_prev_reg <= '0;
    else        ext_prev_reg <= ext_req;
  end

  // ---------------------------------------------------------------------------
  // INTACK detection
  // ---------------------------------------------------------------------------
  logic ack_rd;
  logic ack_rise;

  assign ack_rd        = bus.m1 & bus.iorq;
  assign ack_rise      = ack_rd & ~ack_prev_reg;
  assign int_vector_rd = ack_rd;

  // Previous-cycle INTACK level so that a long acknowledge counts once.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) ack_prev_reg <= 1'b0;
    else        ack_prev_reg <= ack_rd;
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority selection: lowest pending index wins
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] sel;
  logic             any_pending;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    sel         = '0;
    any_pending = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        sel         = SEL_W'(i);
        any_pending = 1'b1;
      end
    end
  end

  // One-hot form of "this source is being acknowledged now".
  logic [NSRC-1:0] ack_hit;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ack_hit
      assign ack_hit[gi] = ack_rise & any_pending & (sel == SEL_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pulse counter
  // ---------------------------------------------------------------------------
  logic cnt_idle;
  logic pulse_start;
  logic pulse_end;

  assign cnt_idle    = (cnt_reg == '0);
  assign pulse_start = ~level_mode & cnt_idle & any_pending;
  assign pulse_end   = ~level_mode & clkcpu_ck & (cnt_reg == CNT_W'(PULSE_LEN));

  // Idle -> 1 on a pending request, then count CPU clocks up to PULSE_LEN and
  // wrap to idle; level mode parks the counter at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (level_mode) begin
      cnt_next = '0;
    end else if (cnt_idle) begin
      if (any_pending) cnt_next = CNT_W'(1);
    end else if (clkcpu_ck) begin
      if (cnt_reg == CNT_W'(PULSE_LEN)) cnt_next = '0;
      else                              cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  // ---------------------------------------------------------------------------
  // Pending and pulse-snapshot bits
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pending
      // Disable clears; a trigger beats an ack or end-of-pulse clear in the same
      // cycle; an unacknowledged pulse drops the requests it was carrying.
      assign pending_next[gi] =
          !src_en[gi]                                   ? 1'b0 :
          trig[gi]                                      ? 1'b1 :
          (ack_hit[gi] || (pulse_end && sampled_reg[gi])) ? 1'b0 :
                                                          pending_reg[gi];

      // Snapshot at pulse start; an acked or disabled source leaves the snapshot
      // so that a later re-trigger during the same pulse survives the pulse end.
      assign sampled_next[gi] =
          level_mode  ? 1'b0 :
          pulse_start ? (pending_reg[gi] & src_en[gi]) :
          pulse_end   ? 1'b0 :
                        (sampled_reg[gi] & ~ack_hit[gi] & src_en[gi]);
    end
  endgenerate

  // Pending and snapshot registers.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      sampled_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      sampled_reg <= sampled_next;
    end
  end

  assign pending = pending_reg;

  // ---------------------------------------------------------------------------
  // n_int generation, retimed to the CPU clock
  // ---------------------------------------------------------------------------
  assign n_int_next = level_mode ? ~|(pending_reg & src_en) : cnt_idle;

  // n_int only moves on a CPU clock edge strobe.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n)         n_int_reg <= 1'b1;
    else if (clkcpu_ck) n_int_reg <= n_int_next;
  end

  assign n_int = n_int_reg;

  // ---------------------------------------------------------------------------
  // IM2 vector
  // ---------------------------------------------------------------------------
`ifdef INTCTL_VECTOR_EN
  logic [7:0] vec_reg, vec_next;

  // Capture the vector of the selected source on the INTACK edge; an empty
  // acknowledge reads as the floating-bus value.
  always_comb begin
    vec_next = vec_reg;
    if (ack_rise) begin
      if (any_pending) vec_next = VEC_BASE | (8'(sel) << 1);
      else             vec_next = 8'hFF;
    end
  end

  // Vector latch; stable for the whole INTACK since it only loads on the edge.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) vec_reg <= 8'hFF;
    else        vec_reg <= vec_next;
  end

  assign int_vector_data = vec_reg;
`else
  // Without vector support the bus floats high regardless of the base value.
  localparam logic [7:0] VEC_FLOAT = VEC_BASE | 8'hFF;

  assign int_vector_data = VEC_FLOAT;
`endif

endmodule
